// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, 2-of-3 majority per bit, start-glitch rejection,
// optional parity and 1/2 stop bits, one-cycle done strobe with per-frame error flags.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_en_sig,
  output logic                 rx_done_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_END  = DW'(DIV - 1);
  localparam logic [SW-1:0] SMP_LO   = SW'(M - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(M);
  localparam logic [SW-1:0] SMP_HI   = SW'(M + 1);
  localparam logic [SW-1:0] SMP_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE} state_t;

  state_t               state, state_n;
  logic                 sync1, sync2, sync3;
  logic                 fall;
  logic [DW-1:0]        tick_cnt;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r, frm_err_r;
  logic                 tick, at_dec, at_end, maj;

  // Synchronizer and edge register idle high so reset never fakes a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx_pin_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall   = sync3 & ~sync2;
  assign tick   = (tick_cnt == DIV_END);
  assign at_dec = tick && (s_cnt == SMP_HI);
  assign at_end = tick && (s_cnt == SMP_END);
  // Third vote is the live sample taken at the decision tick
  assign maj    = (samp[0] & samp[1]) | (samp[0] & sync2) | (samp[1] & sync2);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (rx_en_sig && fall) state_n = S_START;
      S_START: begin
        if (at_dec && maj)  state_n = S_IDLE;
        else if (at_end)    state_n = S_DATA;
      end
      S_DATA:  if (at_end && bit_cnt == BIT_LAST) state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (at_end) state_n = S_STOP;
      S_STOP:  if (at_dec && stop_cnt == STOP_LAST) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (!rx_en_sig && state != S_IDLE && state != S_DONE) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      samp        <= '0;
      shreg       <= '0;
      par_err_r   <= 1'b0;
      frm_err_r   <= 1'b0;
      rx_done_sig <= 1'b0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      rx_done_sig <= 1'b0;

      // Counters restart on every state change so ticks stay aligned to the start edge
      if (state == S_IDLE || state_n != state) begin
        tick_cnt <= '0;
        s_cnt    <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        s_cnt    <= at_end ? '0 : s_cnt + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + DW'(1);
      end

      if (tick && s_cnt == SMP_LO)  samp[0] <= sync2;
      if (tick && s_cnt == SMP_MID) samp[1] <= sync2;

      if (state == S_IDLE && state_n == S_START) begin
        par_err_r <= 1'b0;
        frm_err_r <= 1'b0;
      end

      if (state != S_DATA)          bit_cnt <= '0;
      else if (at_end)              bit_cnt <= bit_cnt + BW'(1);

      if (state != S_STOP)          stop_cnt <= 1'b0;
      else if (at_end)              stop_cnt <= 1'b1;

      if (state == S_DATA && at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};

      if (state == S_PAR && at_dec)
        par_err_r <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);

      if (state == S_STOP && at_dec && !maj) frm_err_r <= 1'b1;

      if (state == S_DONE) begin
        rx_done_sig <= 1'b1;
        rx_data     <= shreg;
        parity_err  <= par_err_r;
        frame_err   <= frm_err_r;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation replacement for the fixed 8N1 receive module. It adds configurable data width, parity, stop-bit count and oversampling, plus majority-vote sampling, start-bit glitch rejection and per-frame error flags. It sits between the asynchronous serial pin and the byte-consuming logic, and presents one word per frame with a single-cycle done strobe.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 115_200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit; even, 8..32
- DATA_BITS, 8, payload width; 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- clk  in  1  single system clock; everything is synchronous to its rising edge
- rst  in  1  reset; synchronous, active-high
- rx_pin_in  in  1  asynchronous serial line; idles high
- rx_en_sig  in  1  receive enable; level
- rx_done_sig  out  1  one-cycle strobe; a frame has completed
- rx_data  out  DATA_BITS  received word, LSB = first bit on the line
- parity_err  out  1  parity mismatch in the last frame; valid with and after rx_done_sig
- frame_err  out  1  a stop bit was sampled low in the last frame; valid with and after rx_done_sig

## Operation
- Synchronizer: rx_pin_in passes through a 2-FF synchronizer, then a 1-FF edge register. Both stages reset to 1.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer truncation; DIV ≥ 1 is required.
  - The counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - The counter is held at 0 in IDLE and restarts on start detection, so ticks are phase-aligned to the falling edge.
- Sampling: inside each bit, the sample counter s runs 0..OVERSAMPLE-1. Samples are taken at ticks s = M-1, M, M+1, with M = OVERSAMPLE/2. The bit value is the 2-of-3 majority, decided at s = M+1.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: when rx_en_sig=1 and a synced falling edge (1→0) occurs, go to START. rx_en_sig=0 blocks detection.
  - START: at the START decision, if the majority is 1 (glitch), return to IDLE with no strobe. Otherwise, at s = OVERSAMPLE-1, go to DATA.
  - DATA: shift DATA_BITS bits LSB-first. Go to PARITY if PARITY≠0, else go to STOP.
  - PARITY: compute the XOR of the data bits and the parity bit.
    - Odd mode: error if the result is 0.
    - Even mode: error if the result is 1.
  - STOP: decide STOP_BITS stop bits. Any stop bit sampled 0 sets frame_err. After the decision of the last stop bit, go to DONE. The remainder of the last stop bit is not waited for.
  - DONE: one cycle. rx_data, parity_err and frame_err load together, rx_done_sig=1. Then go to IDLE.
- Frames with errors still deliver data and still pulse rx_done_sig.
- rx_data and both error flags hold their values until the next DONE.
- rx_en_sig deasserted mid-frame (any state other than IDLE or DONE):
  - The receiver aborts to IDLE on the next clock.
  - There is no strobe, and the outputs are unchanged.
- A line held low (break) is received as a frame of all-zero data with frame_err=1. After DONE, no new start is detected until the line has returned high, because detection requires a 1→0 edge.
- rst asserted at any time:
  - State goes to IDLE and all counters go to 0.
  - Outputs reset: rx_done_sig=0, rx_data=0, parity_err=0, frame_err=0.
  - A frame in progress is discarded.

## Timing
- Start detection: the edge is seen 3 cycles after the pin falls (2 synchronizer stages plus 1 edge register).
- Bit period T = DIV*OVERSAMPLE cycles.
- rx_done_sig rises (N-1)*T + (M+1)*DIV + 4 cycles (±1 cycle) after the pin falls.
  - N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
  - The extra ~4 cycles cover the synchronizer, the edge register and the DONE register.
- rx_done_sig is high for exactly 1 cycle. rx_data is stable in that cycle and afterwards.
- Back-to-back frames with zero idle time are received without loss. DONE occurs about T/2 before the next start edge.
- Jitter tolerance: the sampling window is centred mid-bit, so cumulative baud error up to about ±(M-1)/OVERSAMPLE bit across the frame is tolerated.

## Test plan
Benches use CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16, giving DIV=1 and T=16 cycles.
- 8N1, byte 0xA5 LSB-first, rx_en_sig=1 → exactly one rx_done_sig pulse; rx_data=0xA5; parity_err=0; frame_err=0; pulse at the computed latency ±1 cycle.
- DATA_BITS=7, PARITY=2 (even), 0x55 with the correct parity bit, then 0x55 with the parity bit flipped → rx_data=0x55 both times; parity_err=0, then 1.
- STOP_BITS=2, frame 0x3C with the second stop bit driven low → rx_data=0x3C, frame_err=1. Then a clean 0x3C → frame_err=0.
- Glitches:
  - A 4-cycle low pulse on an idle line → no strobe; the state returns to IDLE.
  - A single-cycle inverted spike at s=M inside data bit 3 of 0x00 → rx_data=0x00 (majority vote).
- Enable and reset:
  - rx_en_sig dropped during data bit 4 → no strobe; rx_data keeps its previous value.
  - rst pulsed mid-frame → all outputs 0; the next clean 0x81 is received correctly.
- Four back-to-back 8N1 frames 0x00, 0xFF, 0x12, 0xED with no idle gap → four strobes with values in order; 0x00 and 0xFF in particular must not be flagged as errors.
